// File: rtl/bm_mult_unit_pkg.sv
// Shared widths and types for the bit-matrix erasure-coding datapath.
// The encoder and decoder blocks reuse these typedefs.
package bm_mult_unit_pkg;

    localparam int W             = 4;
    localparam int PACKET_LENGTH = 8;

    typedef logic [W-1:0]             bm_col_t;
    typedef logic [PACKET_LENGTH-1:0] packet_t;

endpackage : bm_mult_unit_pkg

// File: rtl/bm_row_xor.sv
// One product row: the packets selected by this matrix row, XORed together.
// Purely combinational; there is no carry and no width growth.
module bm_row_xor
    import bm_mult_unit_pkg::*;
(
    input  logic [W-1:0]             row_bits,
    input  logic [PACKET_LENGTH-1:0] packets [W],
    output logic [PACKET_LENGTH-1:0] row_packet
);

    always_comb begin
        // NOTE: assigning a default before the loop keeps this block purely combinational (no latch).
        row_packet = '0;
        for (int j = 0; j < W; j++) begin
            row_packet = row_packet ^ (packets[j] & {PACKET_LENGTH{row_bits[j]}});
        end
    end

endmodule : bm_row_xor

// File: rtl/bm_mult_unit.sv
// GF(2) bit-matrix times packet-vector multiplier with one register stage.
// This block has a valid-only handshake and no backpressure: one result per accepted input.
module bm_mult_unit
    import bm_mult_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             bitmatrix_cols [W],
    input  logic [PACKET_LENGTH-1:0] data_packet    [W],
    output logic                     out_valid,
    output logic [PACKET_LENGTH-1:0] mult_product   [W]
);

    bm_col_t row_bits   [W];
    packet_t row_result [W];

    // The matrix arrives column-major, and each row engine needs its row, so transpose it.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            row_bits[i] = '0;
            for (int j = 0; j < W; j++) begin
                row_bits[i][j] = bitmatrix_cols[j][i];
            end
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_row
        bm_row_xor u_row_xor (
            .row_bits   (row_bits[i]),
            .packets    (data_packet),
            .row_packet (row_result[i])
        );
    end

    // The product register loads only on in_valid, so idle-cycle inputs (even X) never reach it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            // NOTE: the product register is a small register array, not a memory, so it is reset to give a defined zero output.
            for (int i = 0; i < W; i++) begin
                mult_product[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            out_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < W; i++) begin
                    mult_product[i] <= row_result[i];
                end
            end
        end
    end

endmodule : bm_mult_unit

// File: tb/tb_bm_mult_unit.sv
// Directed and streaming checks for bm_mult_unit against a bit-level GF(2) model.
module tb_bm_mult_unit;
    import bm_mult_unit_pkg::*;

    localparam int P = PACKET_LENGTH;

    typedef struct packed {
        logic [W-1:0][W-1:0] cols;
        logic [W-1:0][P-1:0] data;
        logic [W-1:0][P-1:0] exp;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] bitmatrix_cols [W];
    logic [P-1:0] data_packet    [W];
    logic         out_valid;
    logic [P-1:0] mult_product   [W];

    int total;
    int bad;

    bm_mult_unit dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .bitmatrix_cols (bitmatrix_cols),
        .data_packet    (data_packet),
        .out_valid      (out_valid),
        .mult_product   (mult_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W*P-1:0] act, input logic [W*P-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W*P-1:0] packed_product();
        logic [W*P-1:0] r;
        for (int j = 0; j < W; j++) r[j*P +: P] = mult_product[j];
        return r;
    endfunction

    // Bit-level reference: each product bit is a parity over the selected data bits.
    function automatic logic [W*P-1:0] model(input logic [W-1:0][W-1:0] c, input logic [W-1:0][P-1:0] d);
        logic [W*P-1:0] r;
        for (int i = 0; i < W; i++) begin
            for (int b = 0; b < P; b++) begin
                logic bit_v;
                bit_v = 1'b0;
                for (int j = 0; j < W; j++) bit_v = bit_v ^ (c[j][i] & d[j][b]);
                r[i*P + b] = bit_v;
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] c0, c1, c2, c3,
                                input logic [P-1:0] d0, d1, d2, d3,
                                input logic [P-1:0] e0, e1, e2, e3);
        vec_t v;
        v.cols = {c3, c2, c1, c0};
        v.data = {d3, d2, d1, d0};
        v.exp  = {e3, e2, e1, e0};
        return v;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0][W-1:0] c, input logic [W-1:0][P-1:0] d);
        in_valid = v;
        for (int j = 0; j < W; j++) begin
            bitmatrix_cols[j] = c[j];
            data_packet[j]    = d[j];
        end
    endtask

    task automatic drive_random(input logic v, output logic [W-1:0][W-1:0] c, output logic [W-1:0][P-1:0] d);
        for (int j = 0; j < W; j++) begin
            c[j] = W'($urandom);
            d[j] = P'($urandom);
        end
        drive(v, c, d);
    endtask

    vec_t vecs [8];
    logic [W-1:0][W-1:0] rc;
    logic [W-1:0][P-1:0] rd;
    logic [W*P-1:0]      prev_exp;

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = mk(4'b0001, 4'b0010, 4'b0100, 4'b1000, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hA5, 8'h3C, 8'h0F, 8'hF0);
        vecs[1] = mk(4'b0101, 4'b0101, 4'b0101, 4'b0101, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h66, 8'h00, 8'h66, 8'h00);
        vecs[2] = mk(4'b1111, 4'b1111, 4'b1111, 4'b1111, 8'h03, 8'h01, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[3] = mk(4'b1111, 4'b1111, 4'b1111, 4'b1111, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        vecs[4] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[5] = mk(4'b0000, 4'b1111, 4'b1111, 4'b1111, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hC3, 8'hC3, 8'hC3, 8'hC3);
        vecs[6] = mk(4'b1101, 4'b1101, 4'b1101, 4'b1101, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h66, 8'h00, 8'h66, 8'h66);
        vecs[7] = mk(4'b0010, 4'b0100, 4'b1000, 4'b0001, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hF0, 8'hA5, 8'h3C, 8'h0F);

        // Asynchronous reset before any clock edge, then held while inputs toggle.
        rst = 1'b0;
        drive_random(1'b0, rc, rd);
        #1 rst = 1'b1;
        #1;
        check("reset_async_valid", {31'd0, out_valid}, '0);
        check("reset_async_product", packed_product(), '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_random(logic'(k % 2 == 0), rc, rd);
            @(negedge clk);
            check("reset_hold_valid", {31'd0, out_valid}, '0);
            check("reset_hold_product", packed_product(), '0);
        end
        drive_random(1'b0, rc, rd);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("post_release_valid", {31'd0, out_valid}, '0);
        end

        // Table-driven single transactions, each followed by an idle cycle to check hold.
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            drive(1'b1, vecs[n].cols, vecs[n].data);
            @(negedge clk);
            check($sformatf("vec%0d_valid", n), {31'd0, out_valid}, 1);
            check($sformatf("vec%0d_product", n), packed_product(), vecs[n].exp);
            drive_random(1'b0, rc, rd);
            @(negedge clk);
            check($sformatf("vec%0d_idle_valid", n), {31'd0, out_valid}, 0);
            check($sformatf("vec%0d_held", n), packed_product(), vecs[n].exp);
        end

        // Full-throughput streaming.
        prev_exp = '0;
        for (int c = 0; c <= 50; c++) begin
            @(negedge clk);
            if (c > 0) begin
                check("stream_valid", {31'd0, out_valid}, 1);
                check("stream_product", packed_product(), prev_exp);
            end
            if (c < 50) begin
                drive_random(1'b1, rc, rd);
                prev_exp = model(rc, rd);
            end else begin
                drive_random(1'b0, rc, rd);
            end
        end
        @(negedge clk);
        check("stream_end_valid", {31'd0, out_valid}, 0);
        check("stream_end_held", packed_product(), prev_exp);

        // Reset mid-stream: outputs clear between clock edges and stay clear.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive_random(1'b1, rc, rd);
        end
        @(negedge clk);
        check("midstream_valid_before", {31'd0, out_valid}, 1);
        #2 rst = 1'b1;
        #1;
        check("midstream_async_valid", {31'd0, out_valid}, 0);
        check("midstream_async_product", packed_product(), '0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("midstream_hold_valid", {31'd0, out_valid}, 0);
            check("midstream_hold_product", packed_product(), '0);
            drive_random(1'b1, rc, rd);
        end
        @(negedge clk);
        drive_random(1'b0, rc, rd);
        rst = 1'b0;
        @(negedge clk);
        check("midstream_release_valid", {31'd0, out_valid}, 0);
        check("midstream_release_product", packed_product(), '0);
        drive(1'b1, vecs[7].cols, vecs[7].data);
        @(negedge clk);
        check("first_after_reset_valid", {31'd0, out_valid}, 1);
        check("first_after_reset_product", packed_product(), vecs[7].exp);
        drive_random(1'b0, rc, rd);
        @(negedge clk);
        check("first_after_reset_idle", {31'd0, out_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bm_mult_unit
